// File: rtl/fpu_adapter_pkg.sv
// Shared types and constants for the FMA stream adapter.
// Request words pack A, B, C at field indices 0, 1, 2.
package fpu_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_DELIVER
    } state_e;

    localparam int unsigned REQ_A      = 0;
    localparam int unsigned REQ_B      = 1;
    localparam int unsigned REQ_C      = 2;
    localparam int unsigned REQ_FIELDS = 3;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO holding packed {C,B,A} operand words.
// Caller guarantees no push when full and no pop when empty.
module fpu_req_fifo
    import fpu_adapter_pkg::*;
#(
    parameter  int unsigned W     = 96,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = ptr_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fpu_stream_adapter.sv
// Bridges the feeder's pulse interface to the FMA core's AXI4-Stream
// channels, one operation in flight at a time.
module fpu_stream_adapter
    import fpu_adapter_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LAT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  dataA_i,
    input  logic [XLEN-1:0]  dataB_i,
    input  logic [XLEN-1:0]  dataC_i,
    output logic             result_valid_o,
    output logic [XLEN-1:0]  result_data_o,
    output logic             s_axis_a_tvalid_o,
    input  logic             s_axis_a_tready_i,
    output logic [XLEN-1:0]  s_axis_a_tdata_o,
    output logic             s_axis_b_tvalid_o,
    input  logic             s_axis_b_tready_i,
    output logic [XLEN-1:0]  s_axis_b_tdata_o,
    output logic             s_axis_c_tvalid_o,
    input  logic             s_axis_c_tready_i,
    output logic [XLEN-1:0]  s_axis_c_tdata_o,
    input  logic             m_axis_result_tvalid_i,
    output logic             m_axis_result_tready_o,
    input  logic [XLEN-1:0]  m_axis_result_tdata_i,
    output logic             busy_o,
    output logic             overflow_o,
    output logic [LAT_W-1:0] last_latency_o
);

    localparam int unsigned RW = REQ_FIELDS * XLEN;
    localparam int unsigned PW = ptr_w(FIFO_DEPTH);

    state_e            state, state_nx;
    logic              push, pop, full, empty;
    logic [PW:0]       count;
    logic [RW-1:0]     req_wdata, req_rdata;
    logic              a_vld, b_vld, c_vld;
    logic [XLEN-1:0]   a_q, b_q, c_q;
    logic              a_left, b_left, c_left;
    logic              res_hs;
    logic [LAT_W-1:0]  lat_cnt, lat_inc;

    assign req_wdata = {dataC_i, dataB_i, dataA_i};
    assign push      = valid_i && !full;

    fpu_req_fifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (req_wdata),
        .pop   (pop),
        .rdata (req_rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign a_left  = a_vld && !s_axis_a_tready_i;
    assign b_left  = b_vld && !s_axis_b_tready_i;
    assign c_left  = c_vld && !s_axis_c_tready_i;
    assign res_hs  = m_axis_result_tvalid_i && m_axis_result_tready_o;
    assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;

    assign s_axis_a_tvalid_o = a_vld;
    assign s_axis_b_tvalid_o = b_vld;
    assign s_axis_c_tvalid_o = c_vld;
    assign s_axis_a_tdata_o  = a_q;
    assign s_axis_b_tdata_o  = b_q;
    assign s_axis_c_tdata_o  = c_q;
    assign busy_o = (count != '0) || (state != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx               = state;
        pop                    = 1'b0;
        m_axis_result_tready_o = 1'b0;
        result_valid_o         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!(a_left || b_left || c_left)) state_nx = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                m_axis_result_tready_o = 1'b1;
                if (m_axis_result_tvalid_i) state_nx = ST_DELIVER;
            end
            ST_DELIVER: begin
                result_valid_o = 1'b1;
                state_nx       = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Each operand channel retires on its own handshake.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
            c_vld <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else if (pop) begin
            a_vld <= 1'b1;
            b_vld <= 1'b1;
            c_vld <= 1'b1;
            a_q   <= req_rdata[REQ_A*XLEN +: XLEN];
            b_q   <= req_rdata[REQ_B*XLEN +: XLEN];
            c_q   <= req_rdata[REQ_C*XLEN +: XLEN];
        end else begin
            if (a_vld && s_axis_a_tready_i) a_vld <= 1'b0;
            if (b_vld && s_axis_b_tready_i) b_vld <= 1'b0;
            if (c_vld && s_axis_c_tready_i) c_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat_cnt        <= '0;
            last_latency_o <= '0;
            result_data_o  <= '0;
            overflow_o     <= 1'b0;
        end else begin
            if (valid_i && full) overflow_o <= 1'b1;
            if (pop) begin
                lat_cnt <= '0;
            end else if (state == ST_ISSUE || state == ST_WAIT_RES) begin
                lat_cnt <= lat_inc;
            end
            if (res_hs) begin
                result_data_o  <= m_axis_result_tdata_i;
                last_latency_o <= lat_inc;
            end
        end
    end

endmodule

// File: tb/tb_fpu_stream_adapter.sv
// Directed bench for fpu_stream_adapter with a behavioural FMA core
// that answers a fixed number of cycles after its last operand.
module tb_fpu_stream_adapter;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;
    localparam logic [31:0] F5 = 32'h40A00000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] dataA_i, dataB_i, dataC_i;
    logic        result_valid_o;
    logic [31:0] result_data_o;
    logic        s_axis_a_tvalid_o, s_axis_a_tready_i;
    logic [31:0] s_axis_a_tdata_o;
    logic        s_axis_b_tvalid_o, s_axis_b_tready_i;
    logic [31:0] s_axis_b_tdata_o;
    logic        s_axis_c_tvalid_o, s_axis_c_tready_i;
    logic [31:0] s_axis_c_tdata_o;
    logic        m_tvalid;
    logic        m_axis_result_tready_o;
    logic [31:0] m_tdata;
    logic        busy_o, overflow_o;
    logic [15:0] last_latency_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int core_delay = 6;

    logic [31:0] exp_ovf [5];

    fpu_stream_adapter dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .valid_i                (valid_i),
        .dataA_i                (dataA_i),
        .dataB_i                (dataB_i),
        .dataC_i                (dataC_i),
        .result_valid_o         (result_valid_o),
        .result_data_o          (result_data_o),
        .s_axis_a_tvalid_o      (s_axis_a_tvalid_o),
        .s_axis_a_tready_i      (s_axis_a_tready_i),
        .s_axis_a_tdata_o       (s_axis_a_tdata_o),
        .s_axis_b_tvalid_o      (s_axis_b_tvalid_o),
        .s_axis_b_tready_i      (s_axis_b_tready_i),
        .s_axis_b_tdata_o       (s_axis_b_tdata_o),
        .s_axis_c_tvalid_o      (s_axis_c_tvalid_o),
        .s_axis_c_tready_i      (s_axis_c_tready_i),
        .s_axis_c_tdata_o       (s_axis_c_tdata_o),
        .m_axis_result_tvalid_i (m_tvalid),
        .m_axis_result_tready_o (m_axis_result_tready_o),
        .m_axis_result_tdata_i  (m_tdata),
        .busy_o                 (busy_o),
        .overflow_o             (overflow_o),
        .last_latency_o         (last_latency_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (result_valid_o) pulses <= pulses + 1;
    end

    // Stand-in FMA: exact for the vectors used, x*1.0+0 = x.
    function automatic logic [31:0] core_fn(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] c);
        if (a == F1 && b == F2 && c == F3) return F5;
        if (b == F1 && c == 32'h0) return a;
        return a ^ b ^ c;
    endfunction

    logic        got_a, got_b, got_c, running, done_all;
    logic        hs_a, hs_b, hs_c;
    logic [31:0] op_a, op_b, op_c, ea, eb, ec;
    int          cnt;

    assign hs_a = s_axis_a_tvalid_o && s_axis_a_tready_i;
    assign hs_b = s_axis_b_tvalid_o && s_axis_b_tready_i;
    assign hs_c = s_axis_c_tvalid_o && s_axis_c_tready_i;
    assign ea   = got_a ? op_a : s_axis_a_tdata_o;
    assign eb   = got_b ? op_b : s_axis_b_tdata_o;
    assign ec   = got_c ? op_c : s_axis_c_tdata_o;
    assign done_all = (got_a || hs_a) && (got_b || hs_b) && (got_c || hs_c);

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            got_a    <= 1'b0;
            got_b    <= 1'b0;
            got_c    <= 1'b0;
            running  <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            cnt      <= 0;
        end else if (running) begin
            if (m_tvalid && m_axis_result_tready_o) begin
                m_tvalid <= 1'b0;
                running  <= 1'b0;
            end else if (!m_tvalid) begin
                if (cnt == 0) m_tvalid <= 1'b1;
                else          cnt <= cnt - 1;
            end
        end else begin
            if (hs_a) begin got_a <= 1'b1; op_a <= s_axis_a_tdata_o; end
            if (hs_b) begin got_b <= 1'b1; op_b <= s_axis_b_tdata_o; end
            if (hs_c) begin got_c <= 1'b1; op_c <= s_axis_c_tdata_o; end
            if (done_all) begin
                running <= 1'b1;
                got_a   <= 1'b0;
                got_b   <= 1'b0;
                got_c   <= 1'b0;
                cnt     <= core_delay - 2;
                m_tdata <= core_fn(ea, eb, ec);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        valid_i = 1'b1;
        dataA_i = a;
        dataB_i = b;
        dataC_i = c;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic wait_res(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk_i);
            if (result_valid_o) ok = 1'b1;
        end
    endtask

    task automatic set_rdy(input logic v);
        s_axis_a_tready_i = v;
        s_axis_b_tready_i = v;
        s_axis_c_tready_i = v;
    endtask

    initial begin
        bit ok;
        int p0;
        exp_ovf = '{32'hAAAA0000, F1, F2, F3, F4};
        rst_i   = 1'b0;
        valid_i = 1'b0;
        dataA_i = '0;
        dataB_i = '0;
        dataC_i = '0;
        set_rdy(1'b1);
        repeat (3) @(negedge clk_i);
        chk("rst_rvalid", 32'(result_valid_o), 0);
        chk("rst_rdata", result_data_o, 0);
        chk("rst_avalid", 32'(s_axis_a_tvalid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_lat", 32'(last_latency_o), 0);
        chk("rst_rtready", 32'(m_axis_result_tready_o), 0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // basic: 1*2+3, result six cycles after operand handshake
        send(F1, F2, F3);
        chk("t1_c1_avalid", 32'(s_axis_a_tvalid_o), 0);
        chk("t1_c1_busy", 32'(busy_o), 1);
        @(negedge clk_i);
        chk("t1_c2_avalid", 32'(s_axis_a_tvalid_o), 1);
        chk("t1_c2_adata", s_axis_a_tdata_o, F1);
        chk("t1_c2_bdata", s_axis_b_tdata_o, F2);
        chk("t1_c2_cdata", s_axis_c_tdata_o, F3);
        @(negedge clk_i);
        chk("t1_c3_avalid", 32'(s_axis_a_tvalid_o), 0);
        chk("t1_c3_rtready", 32'(m_axis_result_tready_o), 1);
        repeat (5) @(negedge clk_i);
        chk("t1_c8_rvalid", 32'(result_valid_o), 0);
        @(negedge clk_i);
        chk("t1_c9_rvalid", 32'(result_valid_o), 1);
        chk("t1_c9_rdata", result_data_o, F5);
        chk("t1_c9_lat", 32'(last_latency_o), 7);
        @(negedge clk_i);
        chk("t1_c10_rvalid", 32'(result_valid_o), 0);
        chk("t1_c10_busy", 32'(busy_o), 0);
        chk("t1_c10_hold", result_data_o, F5);

        // b channel stalled for three cycles
        s_axis_b_tready_i = 1'b0;
        send(32'h12345678, F1, 32'h0);
        @(negedge clk_i);
        chk("t2_c2_abc", {29'h0, s_axis_a_tvalid_o, s_axis_b_tvalid_o,
                          s_axis_c_tvalid_o}, 32'h7);
        @(negedge clk_i);
        chk("t2_c3_abc", {29'h0, s_axis_a_tvalid_o, s_axis_b_tvalid_o,
                          s_axis_c_tvalid_o}, 32'h2);
        chk("t2_c3_bdata", s_axis_b_tdata_o, F1);
        @(negedge clk_i);
        chk("t2_c4_bvalid", 32'(s_axis_b_tvalid_o), 1);
        chk("t2_c4_rtready", 32'(m_axis_result_tready_o), 0);
        @(negedge clk_i);
        s_axis_b_tready_i = 1'b1;
        chk("t2_c5_bvalid", 32'(s_axis_b_tvalid_o), 1);
        chk("t2_c5_bdata", s_axis_b_tdata_o, F1);
        chk("t2_c5_rtready", 32'(m_axis_result_tready_o), 0);
        @(negedge clk_i);
        chk("t2_c6_bvalid", 32'(s_axis_b_tvalid_o), 0);
        chk("t2_c6_rtready", 32'(m_axis_result_tready_o), 1);
        wait_res(20, ok);
        chk("t2_res_seen", 32'(ok), 1);
        chk("t2_rdata", result_data_o, 32'h12345678);
        chk("t2_lat", 32'(last_latency_o), 10);
        @(negedge clk_i);

        // push and pop in the same IDLE cycle
        set_rdy(1'b0);
        send(32'h11111111, F1, 32'h0);
        send(32'h22222222, F1, 32'h0);
        chk("t4_pre_count", 32'(dut.u_fifo.count), 1);
        set_rdy(1'b1);
        wait_res(30, ok);
        chk("t4_p_seen", 32'(ok), 1);
        chk("t4_p_data", result_data_o, 32'h11111111);
        @(negedge clk_i);
        send(32'h33333333, F1, 32'h0);
        chk("t4_count", 32'(dut.u_fifo.count), 1);
        chk("t4_ovf", 32'(overflow_o), 0);
        chk("t4_q_adata", s_axis_a_tdata_o, 32'h22222222);
        wait_res(30, ok);
        chk("t4_q_seen", 32'(ok), 1);
        chk("t4_q_data", result_data_o, 32'h22222222);
        wait_res(30, ok);
        chk("t4_r_seen", 32'(ok), 1);
        chk("t4_r_data", result_data_o, 32'h33333333);
        repeat (2) @(negedge clk_i);

        // overflow: one op held in ISSUE, then five more requests
        core_delay = 3;
        set_rdy(1'b0);
        send(32'hAAAA0000, F1, 32'h0);
        repeat (2) @(negedge clk_i);
        send(F1, F1, 32'h0);
        send(F2, F1, 32'h0);
        send(F3, F1, 32'h0);
        send(F4, F1, 32'h0);
        chk("t3_ovf_4", 32'(overflow_o), 0);
        chk("t3_count_4", 32'(dut.u_fifo.count), 4);
        send(F5, F1, 32'h0);
        chk("t3_ovf_5", 32'(overflow_o), 1);
        set_rdy(1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_res(40, ok);
            chk($sformatf("t3_seen%0d", k), 32'(ok), 1);
            chk($sformatf("t3_data%0d", k), result_data_o, exp_ovf[k]);
        end
        chk("t3_ovf_end", 32'(overflow_o), 1);
        wait_res(30, ok);
        chk("t3_no_extra", 32'(ok), 0);
        chk("t3_busy", 32'(busy_o), 0);

        // asynchronous reset while waiting for the result
        core_delay = 20;
        send(32'h0BADF00D, F1, 32'h0);
        repeat (3) @(negedge clk_i);
        chk("t5_pre_rtready", 32'(m_axis_result_tready_o), 1);
        chk("t5_pre_busy", 32'(busy_o), 1);
        #1 rst_i = 1'b0;
        #1;
        chk("t5_rtready", 32'(m_axis_result_tready_o), 0);
        chk("t5_busy", 32'(busy_o), 0);
        chk("t5_abc", {29'h0, s_axis_a_tvalid_o, s_axis_b_tvalid_o,
                       s_axis_c_tvalid_o}, 0);
        chk("t5_rvalid", 32'(result_valid_o), 0);
        chk("t5_ovf", 32'(overflow_o), 0);
        chk("t5_rdata", result_data_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        core_delay = 6;
        @(negedge clk_i);
        send(32'h55555555, F1, 32'h0);
        wait_res(30, ok);
        chk("t5_post_seen", 32'(ok), 1);
        chk("t5_post_data", result_data_o, 32'h55555555);
        chk("t5_post_lat", 32'(last_latency_o), 7);
        @(negedge clk_i);

        // latency counter saturation
        core_delay = 70000;
        p0 = pulses;
        send(32'h77777777, F1, 32'h0);
        wait_res(70100, ok);
        chk("t6_seen", 32'(ok), 1);
        chk("t6_lat", 32'(last_latency_o), 32'hFFFF);
        chk("t6_data", result_data_o, 32'h77777777);
        repeat (5) @(negedge clk_i);
        chk("t6_pulses", 32'(pulses - p0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
